io_bus_arbiter: RTL and testbench

Sequences and shares the single IO register port (status / LED / switch registers) between `NREQ` bus masters: the CPU plus auxiliary engines such as a display refresher or debug port. Each master issues one read or write at a time through a request/done handshake. The arbiter grants round-robin, drives exactly one single-cycle `pread`/`pwrite` strobe per access, and registers the returned data. A lock option lets one master perform back-to-back accesses atomically, e.g. read status and then write LEDs, for a bounded number of accesses.

---
 rtl/io_bus_arbiter_pkg.sv | 19 +
 rtl/rr_picker.sv | 33 +++
 rtl/io_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_io_bus_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_arbiter_pkg.sv
// Shared state encoding, register map and widths for the IO register port arbiter.
package io_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam logic [1:0] IO_STATUS = 2'b00;
  localparam logic [1:0] IO_LED    = 2'b01;
  localparam logic [1:0] IO_SW_LO  = 2'b10;
  localparam logic [1:0] IO_SW_HI  = 2'b11;

  localparam int IO_AW  = 2;
  localparam int IO_WDW = 12;
  localparam int IO_RDW = 32;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first requester after 'last', wrapping
// around; valid stays low when nobody requests.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IDXW = (NREQ > 2) ? 2 : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] idx,
  output logic            valid
);

  logic [IDXW-1:0] cand;
  logic            hit;

  // Scan candidates last+1 .. last+NREQ and latch the first one that requests.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    hit   = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      cand        = IDXW'((int'(last) + off) % NREQ);
      hit         = !valid && req[cand];
      grant[cand] = grant[cand] | hit;
      idx         = hit ? cand : idx;
      valid       = valid | hit;
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares the single IO register port between NREQ masters: round-robin grant,
// one registered strobe per access, optional bounded lock for atomic sequences.
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int LOCK_MAX = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ-1:0]        we_i,
  input  logic [2*NREQ-1:0]      addr_i,
  input  logic [12*NREQ-1:0]     wdata_i,
  input  logic [NREQ-1:0]        lock_i,
  output logic [NREQ-1:0]        done_o,
  output logic [31:0]            rdata_o,
  output logic                   busy_o,
  output logic                   pread_o,
  output logic                   pwrite_o,
  output logic [1:0]             paddr_o,
  output logic [11:0]            pwdata_o,
  input  logic [31:0]            prdata_i
);

  localparam int         IDXW     = (NREQ > 2) ? 2 : 1;
  localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);

  arb_state_t        state, state_nxt;
  logic [IDXW-1:0]   owner, owner_nxt;
  logic [IDXW-1:0]   last, last_nxt;
  logic [IDXW-1:0]   lock_owner, lock_owner_nxt;
  logic              locked, locked_nxt;
  logic [3:0]        lock_cnt, lock_cnt_nxt;
  logic              cmd_we, cmd_we_nxt;
  logic [IO_AW-1:0]  paddr_nxt;
  logic [IO_WDW-1:0] pwdata_nxt;
  logic [IO_RDW-1:0] rdata_nxt;
  logic [NREQ-1:0]   done_nxt;
  logic              pread_nxt, pwrite_nxt, busy_nxt;

  logic              lock_drop;
  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   pick_grant;
  logic [IDXW-1:0]   pick_idx;
  logic              pick_valid;

  // An owner that lets go of lock_i in IDLE loses its exclusivity immediately.
  assign lock_drop = locked && !lock_i[lock_owner];
  assign eligible  = (locked && !lock_drop) ? (req_i & (NREQ'(1) << lock_owner)) : req_i;

  rr_picker #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_picker (
    .req   (eligible),
    .last  (last),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Next-state, command capture and registered-output values per state.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_nxt       = last;
    lock_owner_nxt = lock_owner;
    locked_nxt     = locked;
    lock_cnt_nxt   = lock_cnt;
    cmd_we_nxt     = cmd_we;
    paddr_nxt      = paddr_o;
    pwdata_nxt     = pwdata_o;
    rdata_nxt      = rdata_o;
    done_nxt       = '0;
    pread_nxt      = 1'b0;
    pwrite_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (lock_drop) begin
          locked_nxt   = 1'b0;
          lock_cnt_nxt = 4'd0;
        end else begin
          locked_nxt   = locked;
        end
        if (pick_valid) begin
          owner_nxt  = pick_idx;
          cmd_we_nxt = |(we_i & pick_grant);
          paddr_nxt  = addr_i[IO_AW*pick_idx +: IO_AW];
          pwdata_nxt = wdata_i[IO_WDW*pick_idx +: IO_WDW];
          pwrite_nxt = |(we_i & pick_grant);
          pread_nxt  = !(|(we_i & pick_grant));
          state_nxt  = ACCESS;
        end else begin
          state_nxt  = IDLE;
        end
      end
      ACCESS: begin
        rdata_nxt = cmd_we ? '0 : prdata_i;
        done_nxt  = NREQ'(1) << owner;
        state_nxt = DONE;
      end
      DONE: begin
        last_nxt = owner;
        // Cap reached: releasing with last = owner drops it to lowest priority.
        if (lock_i[owner] && (lock_cnt < LOCK_LIM)) begin
          locked_nxt     = 1'b1;
          lock_owner_nxt = owner;
          lock_cnt_nxt   = lock_cnt + 4'd1;
        end else begin
          locked_nxt     = 1'b0;
          lock_cnt_nxt   = 4'd0;
        end
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt == ACCESS) || (state_nxt == DONE);
  end

  // State, arbitration bookkeeping and all outputs, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last       <= IDXW'(NREQ - 1);
      lock_owner <= '0;
      locked     <= 1'b0;
      lock_cnt   <= 4'd0;
      cmd_we     <= 1'b0;
      paddr_o    <= '0;
      pwdata_o   <= '0;
      rdata_o    <= '0;
      done_o     <= '0;
      pread_o    <= 1'b0;
      pwrite_o   <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last       <= last_nxt;
      lock_owner <= lock_owner_nxt;
      locked     <= locked_nxt;
      lock_cnt   <= lock_cnt_nxt;
      cmd_we     <= cmd_we_nxt;
      paddr_o    <= paddr_nxt;
      pwdata_o   <= pwdata_nxt;
      rdata_o    <= rdata_nxt;
      done_o     <= done_nxt;
      pread_o    <= pread_nxt;
      pwrite_o   <= pwrite_nxt;
      busy_o     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed scenarios then random traffic,
// predicted by a transaction-level model of the grant and lock rules.
module tb_io_bus_arbiter;
  import io_arb_pkg::*;

  localparam int N  = 2;
  localparam int LM = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_i, we_i, lock_i;
  logic [2*N-1:0]  addr_i;
  logic [12*N-1:0] wdata_i;
  logic [31:0]     prdata_i;
  logic [N-1:0]    done_o;
  logic [31:0]     rdata_o;
  logic            busy_o, pread_o, pwrite_o;
  logic [1:0]      paddr_o;
  logic [11:0]     pwdata_o;

  io_bus_arbiter #(.NREQ(N), .LOCK_MAX(LM)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .lock_i(lock_i), .done_o(done_o), .rdata_o(rdata_o),
    .busy_o(busy_o), .pread_o(pread_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
    .pwdata_o(pwdata_o), .prdata_i(prdata_i)
  );

  always #5 clk = ~clk;

  // Master-side intent and reference model state.
  logic        req  [N];
  logic        we   [N];
  logic [1:0]  addr [N];
  logic [11:0] wdata[N];
  logic        lock [N];
  int          m_last, m_lock_owner, m_lock_cnt;
  logic        m_locked;
  logic [31:0] m_rdata;
  int          total = 0;
  int          bad   = 0;
  int          w;
  int          lock_order [7] = '{0, 0, 0, 0, 0, 1, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int k = 0; k < N; k++) begin
      req_i[k]            = req[k];
      we_i[k]             = we[k];
      lock_i[k]           = lock[k];
      addr_i[2*k +: 2]    = addr[k];
      wdata_i[12*k +: 12] = wdata[k];
    end
  endtask

  task automatic model_reset();
    m_last = N - 1; m_locked = 1'b0; m_lock_owner = 0; m_lock_cnt = 0; m_rdata = 32'd0;
  endtask

  task automatic set_cmd(input int k, input logic is_wr, input logic [1:0] a, input logic [11:0] d);
    req[k] = 1'b1; we[k] = is_wr; addr[k] = a; wdata[k] = d;
  endtask

  // One arbitration opportunity starting in IDLE; returns the served master or -1.
  task automatic step(input logic [31:0] pd, output int win);
    logic [N-1:0] elig;
    logic [N-1:0] oh;
    logic [31:0]  exp_rd;
    int           c;
    apply();
    if (m_locked && !lock[m_lock_owner]) begin
      m_locked = 1'b0; m_lock_cnt = 0;
    end
    for (int k = 0; k < N; k++) elig[k] = req[k] && (!m_locked || k == m_lock_owner);
    win = -1;
    for (int off = 1; off <= N; off++) begin
      c = (m_last + off) % N;
      if (win < 0 && elig[c]) win = c;
    end
    @(posedge clk); #1;
    if (win < 0) begin
      check("idle_busy", 32'(busy_o), 32'd0);
      check("idle_strobes", 32'({pread_o, pwrite_o}), 32'd0);
      check("idle_done", 32'(done_o), 32'd0);
      check("idle_rdata_hold", rdata_o, m_rdata);
    end else begin
      check("acc_pread", 32'(pread_o), 32'(!we[win]));
      check("acc_pwrite", 32'(pwrite_o), 32'(we[win]));
      check("acc_paddr", 32'(paddr_o), 32'(addr[win]));
      check("acc_pwdata", 32'(pwdata_o), 32'(wdata[win]));
      check("acc_busy", 32'(busy_o), 32'd1);
      check("acc_done", 32'(done_o), 32'd0);
      prdata_i = pd;
      @(posedge clk); #1;
      exp_rd = we[win] ? 32'd0 : pd;
      oh = '0; oh[win] = 1'b1;
      check("done_onehot", 32'(done_o), 32'(oh));
      check("done_rdata", rdata_o, exp_rd);
      check("done_strobes", 32'({pread_o, pwrite_o}), 32'd0);
      check("done_busy", 32'(busy_o), 32'd1);
      m_rdata = exp_rd;
      m_last  = win;
      if (lock[win] && m_lock_cnt < LM) begin
        m_locked = 1'b1; m_lock_owner = win; m_lock_cnt++;
      end else begin
        m_locked = 1'b0; m_lock_cnt = 0;
      end
      req[win] = 1'b0;
      @(posedge clk); #1;
      check("post_busy", 32'(busy_o), 32'd0);
      check("post_done", 32'(done_o), 32'd0);
      check("post_rdata_hold", rdata_o, m_rdata);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = 2'd0; wdata[k] = 12'd0; lock[k] = 1'b0;
    end
    prdata_i = 32'd0;
    apply();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_strobes", 32'({pread_o, pwrite_o}), 32'd0);
    check("rst_paddr", 32'(paddr_o), 32'd0);
    check("rst_pwdata", 32'(pwdata_o), 32'd0);
    reset = 1'b0;

    // Single read, then single write.
    set_cmd(0, 1'b0, IO_SW_LO, 12'd0);
    step(32'h2A, w);
    check("single_read_who", 32'(w), 32'd0);
    set_cmd(1, 1'b1, IO_LED, 12'hABC);
    step(32'hDEAD_BEEF, w);
    check("single_write_who", 32'(w), 32'd1);

    // Contention: both masters keep reading.
    for (int i = 0; i < 4; i++) begin
      if (!req[0]) set_cmd(0, 1'b0, IO_STATUS, 12'd0);
      if (!req[1]) set_cmd(1, 1'b0, IO_SW_HI, 12'd0);
      step($urandom(), w);
      check("contention_order", 32'(w), 32'(i % 2));
    end
    req[0] = 1'b0; req[1] = 1'b0;

    // Lock held by master0 with master1 waiting.
    lock[0] = 1'b1;
    set_cmd(1, 1'b0, IO_STATUS, 12'd0);
    for (int i = 0; i < 7; i++) begin
      if (!req[0]) set_cmd(0, 1'(i % 2), IO_LED, 12'(i * 37));
      step($urandom(), w);
      check("lock_order", 32'(w), 32'(lock_order[i]));
    end
    lock[0] = 1'b0; req[0] = 1'b0; req[1] = 1'b0;
    step($urandom(), w);
    check("lock_idle", 32'(w + 1), 32'd0);

    // Early unlock after two locked accesses.
    lock[0] = 1'b1;
    set_cmd(0, 1'b0, IO_SW_LO, 12'd0);
    step($urandom(), w);
    check("unlock_first", 32'(w), 32'd0);
    set_cmd(0, 1'b1, IO_LED, 12'h123);
    set_cmd(1, 1'b0, IO_SW_HI, 12'd0);
    step($urandom(), w);
    check("unlock_second", 32'(w), 32'd0);
    lock[0] = 1'b0;
    set_cmd(0, 1'b0, IO_STATUS, 12'd0);
    step($urandom(), w);
    check("unlock_m1_next", 32'(w), 32'd1);
    step($urandom(), w);
    check("unlock_m0_after", 32'(w), 32'd0);

    // Reset while master1's write strobe is up.
    set_cmd(1, 1'b1, IO_LED, 12'h5A5);
    apply();
    @(posedge clk); #1;
    check("pre_rst_pwrite", 32'(pwrite_o), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_strobes", 32'({pread_o, pwrite_o}), 32'd0);
    check("midrst_done", 32'(done_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    reset = 1'b0;
    model_reset();
    set_cmd(0, 1'b0, IO_SW_LO, 12'd0);
    step($urandom(), w);
    check("after_rst_first", 32'(w), 32'd0);
    step($urandom(), w);
    check("after_rst_reissue", 32'(w), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!req[k] && $urandom_range(0, 1) == 1)
          set_cmd(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 12'($urandom()));
        lock[k] = ($urandom_range(0, 2) == 0);
      end
      step($urandom(), w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
